// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit: per-register countdown scoreboard plus stall/redirect arbitration for ID.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int LOAD_LAT = 1,
   localparam int AW = $clog2(NUM_REGS),
   localparam int CW = $clog2(LOAD_LAT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [AW-1:0]       id_rs1,
   input  logic [AW-1:0]       id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [AW-1:0]       id_rd,
   input  logic                id_is_load,
   input  logic                ex_redirect,
   output logic                stall_pc,
   output logic                stall_if_id,
   output logic                bubble_id_ex,
   output logic                flush_if_id,
   output logic [NUM_REGS-1:0] pending
`ifdef HAZARD_STATS_EN
   ,
   output logic [31:0]         stat_stall_cycles,
   output logic [31:0]         stat_flush_cycles
`endif
);

   logic [CW-1:0]       r_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] w_nz;
   logic                w_hazard;
   logic                w_issue;

   always_comb begin
      w_nz = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_nz[r] = (r_cnt[r] != '0);
      end
   end

   // Entry 0 is held at zero, so x0 can never raise a hazard.
   assign w_hazard = id_valid & ((id_use_rs1 & w_nz[id_rs1]) | (id_use_rs2 & w_nz[id_rs2]));
   assign w_issue  = id_valid & ~w_hazard & ~ex_redirect;

   assign pending      = w_nz;
   assign flush_if_id  = ex_redirect;
   assign bubble_id_ex = ex_redirect | w_hazard;
   assign stall_pc     = ~ex_redirect & w_hazard;
   assign stall_if_id  = ~ex_redirect & w_hazard;

   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rst || r == 0) begin
            r_cnt[r] <= '0;
         end else if (w_issue && id_is_load && id_rd == AW'(r)) begin
            // A new load restarts the countdown even if one is in flight.
            r_cnt[r] <= CW'(LOAD_LAT);
         end else if (w_nz[r]) begin
            r_cnt[r] <= r_cnt[r] - CW'(1);
         end
      end
   end

`ifdef HAZARD_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_cycles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_flush_cycles <= '0;
      end else begin
         if (w_hazard && !ex_redirect) r_stall_cycles <= sat_inc(r_stall_cycles);
         if (ex_redirect)              r_flush_cycles <= sat_inc(r_flush_cycles);
      end
   end

   assign stat_stall_cycles = r_stall_cycles;
   assign stat_flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: one instance with LOAD_LAT=1 and one with LOAD_LAT=3 share the ID inputs.
module tb_hazard_scoreboard;

   localparam int NR = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [AW-1:0] id_rs1, id_rs2, id_rd;
   logic          id_use_rs1, id_use_rs2, id_is_load, ex_redirect;

   logic          s_pc1, s_ifid1, b1, f1;
   logic [NR-1:0] p1;
   logic          s_pc3, s_ifid3, b3, f3;
   logic [NR-1:0] p3;
`ifdef HAZARD_STATS_EN
   logic [31:0]   st1, fl1, st3, fl3;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.NUM_REGS(NR), .LOAD_LAT(1)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .stall_pc(s_pc1), .stall_if_id(s_ifid1), .bubble_id_ex(b1), .flush_if_id(f1),
      .pending(p1)
`ifdef HAZARD_STATS_EN
      , .stat_stall_cycles(st1), .stat_flush_cycles(fl1)
`endif
   );

   hazard_scoreboard #(.NUM_REGS(NR), .LOAD_LAT(3)) u3 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .stall_pc(s_pc3), .stall_if_id(s_ifid3), .bubble_id_ex(b3), .flush_if_id(f3),
      .pending(p3)
`ifdef HAZARD_STATS_EN
      , .stat_stall_cycles(st3), .stat_flush_cycles(fl3)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_is_load = 0; ex_redirect = 0;
   endtask

   task automatic load(input logic [AW-1:0] rd);
      idle();
      id_valid = 1; id_is_load = 1; id_rd = rd;
   endtask

   task automatic use_reg(input logic [AW-1:0] rs1, input logic u1v,
                          input logic [AW-1:0] rs2, input logic u2v);
      idle();
      id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1v; id_rs2 = rs2; id_use_rs2 = u2v;
      id_rd = 5'd20;
   endtask

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;
      #1;
      chk("reset_pending1", p1, 32'h0);
      chk("reset_pending3", p3, 32'h0);
      chk("reset_ctrl1", {28'h0, s_pc1, s_ifid1, b1, f1}, 32'h0);
      chk("reset_ctrl3", {28'h0, s_pc3, s_ifid3, b3, f3}, 32'h0);

      // LOAD_LAT=1 classic load-use
      load(5'd5); #1;
      chk("lat1_load_nostall", {31'h0, s_pc1}, 32'h0);
      tick();
      use_reg(5'd5, 1, 5'd0, 0); #1;
      chk("lat1_dep_stall", {28'h0, s_pc1, s_ifid1, b1, f1}, 32'hE);
      chk("lat1_pending5", p1, 32'h20);
      tick(); #1;
      chk("lat1_dep_issue", {28'h0, s_pc1, s_ifid1, b1, f1}, 32'h0);
      chk("lat1_pending_clear", p1, 32'h0);
      chk("lat3_still_stall", {31'h0, s_pc3}, 32'h1);
      idle(); repeat (4) tick();
      chk("drain1_pending3", p3, 32'h0);

      // LOAD_LAT=3, dependent through rs2 stalls 3 cycles
      load(5'd7); tick();
      use_reg(5'd0, 0, 5'd7, 1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("lat3_stall_c%0d", i), {28'h0, s_pc3, s_ifid3, b3, f3}, 32'hE);
         chk($sformatf("lat3_pend7_c%0d", i), p3, 32'h80);
         tick();
      end
      #1;
      chk("lat3_dep_issue", {31'h0, s_pc3}, 32'h0);
      chk("lat3_pend_clear", p3, 32'h0);

      // load to x0 is ignored
      load(5'd0); tick();
      use_reg(5'd0, 1, 5'd0, 1); #1;
      chk("x0_nostall1", {31'h0, s_pc1}, 32'h0);
      chk("x0_nostall3", {31'h0, s_pc3}, 32'h0);
      chk("x0_pending3", p3, 32'h0);
      idle(); tick();

      // independent consumer, and matching rs1 with use_rs1=0
      load(5'd5); tick();
      use_reg(5'd6, 1, 5'd5, 0); #1;
      chk("indep_nostall3", {31'h0, s_pc3}, 32'h0);
      chk("indep_pend3", p3, 32'h20);
      idle(); repeat (4) tick();

      // hazard plus redirect: flush wins, stalled load does not set scoreboard
      load(5'd5); tick();
      load(5'd6); id_rs1 = 5'd5; id_use_rs1 = 1; ex_redirect = 1; #1;
      chk("redir_ctrl3", {28'h0, s_pc3, s_ifid3, b3, f3}, 32'h3);
      chk("redir_ctrl1", {28'h0, s_pc1, s_ifid1, b1, f1}, 32'h3);
      tick();
      idle(); #1;
      chk("redir_pend3", p3, 32'h20);
      chk("redir_pend1", p1, 32'h0);
      repeat (4) tick();

      // back-to-back loads to x9 reload the counter
      load(5'd9); tick();
      load(5'd9); #1;
      chk("b2b_nostall", {31'h0, s_pc3}, 32'h0);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("b2b_pend9_c%0d", i), p3, 32'h200);
         tick();
      end
      #1;
      chk("b2b_pend_clear", p3, 32'h0);

      // reset mid-countdown
      load(5'd4); tick();
      idle(); tick();
      rst = 1; #1;
      chk("rst_pre_pend4", p3, 32'h10);
      tick();
      rst = 0;
      use_reg(5'd4, 1, 5'd0, 0); #1;
      chk("rst_pend3", p3, 32'h0);
      chk("rst_dep_nostall3", {28'h0, s_pc3, s_ifid3, b3, f3}, 32'h0);
`ifdef HAZARD_STATS_EN
      chk("rst_stat_stall3", st3, 32'h0);
      chk("rst_stat_flush3", fl3, 32'h0);
      chk("rst_stat_stall1", st1, 32'h0);
      chk("rst_stat_flush1", fl1, 32'h0);
`endif
      idle(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
